rv32i_decode_stage: RTL and testbench

Consumer end of the RV32I instruction-word encoding: accepts 32-bit instruction words (plus PC) over a valid/ready handshake and emits fully decoded fields, sign-extended immediates and an illegal-instruction flag, one cycle later.
- Registered output stage backed by a one-entry skid buffer gives full throughput under backpressure.
- Sits between the fetch/instruction source (or the random instruction generator in verification) and execute.
- Keeps saturating decode and illegal counters for coverage.

---
 rtl/rv32i_decode_stage_pkg.sv | 55 +++++
 rtl/rv32i_decode_stage_if.sv | 35 +++
 rtl/rv32i_decode_stage_comb.sv | 95 +++++++++
 rtl/rv32i_decode_stage.sv | 81 ++++++++
 tb/tb_rv32i_decode_stage.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_decode_stage_pkg.sv
// rtl/rv32i_decode_stage_pkg.sv - RV32I opcode constants, immediate formats and decoded record types
package rv32i_decode_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;

  typedef union packed {
    logic [31:0]   raw;
    instr_fields_t f;
  } instr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    imm_sel_t    imm_sel;
    logic        alt;
    logic        rd_we;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// rtl/rv32i_decode_stage_if.sv - instruction-in / decoded-record-out handshake bundle
interface rv32i_decode_stage_if;
  import rv32i_decode_stage_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  imm_sel_t    out_imm_sel;
  logic        out_alt;
  logic        out_rd_we;
  logic        out_illegal;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_opcode, out_funct3, out_rd,
           out_rs1, out_rs2, out_imm, out_imm_sel, out_alt, out_rd_we, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_opcode, out_funct3, out_rd,
           out_rs1, out_rs2, out_imm, out_imm_sel, out_alt, out_rd_we, out_illegal
  );
endinterface

// File: rtl/rv32i_decode_stage_comb.sv
// rtl/rv32i_decode_stage_comb.sv - combinational RV32I base decoder, instr_t to decoded_t
module rv32i_decode_comb
  import rv32i_decode_stage_pkg::*;
(
  input  instr_t      instr,
  input  logic [31:0] pc,
  output decoded_t    dec
);

  logic [31:0] w;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal, writes_rd, alt;
  imm_sel_t    sel;

  assign w  = instr.raw;
  assign f3 = instr.f.funct3;
  assign f7 = instr.f.funct7;

  assign imm_i = {{20{w[31]}}, w[31:20]};
  assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
  assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  assign imm_u = {w[31:12], 12'b0};
  assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

  always_comb begin
    legal     = 1'b1;
    writes_rd = 1'b0;
    alt       = 1'b0;
    sel       = IMM_NONE;
    case (instr.f.opcode)
      OP_LUI, OP_AUIPC: begin sel = IMM_U; writes_rd = 1'b1; end
      OP_JAL:           begin sel = IMM_J; writes_rd = 1'b1; end
      OP_JALR: begin
        sel = IMM_I; writes_rd = 1'b1;
        legal = (f3 == 3'b000);
      end
      OP_LOAD: begin
        sel = IMM_I; writes_rd = 1'b1;
        legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      OP_STORE: begin
        sel = IMM_S;
        legal = (f3 <= 3'b010);
      end
      OP_BRANCH: begin
        sel = IMM_B;
        legal = (f3[2:1] != 2'b01);
      end
      OP_IMM: begin
        sel = IMM_I; writes_rd = 1'b1;
        // Shift-immediates reuse the funct7 field; only srai may set the variant bit.
        if (f3 == 3'b001) begin
          legal = (f7 == F7_BASE);
        end else if (f3 == 3'b101) begin
          legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          alt   = (f7 == F7_ALT);
        end
      end
      OP_REG: begin
        writes_rd = 1'b1;
        legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101));
        alt   = (f7 == F7_ALT);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.instr   = w;
    dec.opcode  = instr.f.opcode;
    dec.funct3  = f3;
    dec.rd      = instr.f.rd;
    dec.rs1     = instr.f.rs1;
    dec.rs2     = instr.f.rs2;
    dec.illegal = !legal;
    if (legal) begin
      dec.imm_sel = sel;
      dec.alt     = alt;
      dec.rd_we   = writes_rd && (instr.f.rd != 5'd0);
      case (sel)
        IMM_I:   dec.imm = imm_i;
        IMM_S:   dec.imm = imm_s;
        IMM_B:   dec.imm = imm_b;
        IMM_U:   dec.imm = imm_u;
        IMM_J:   dec.imm = imm_j;
        default: dec.imm = 32'd0;
      endcase
    end
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// rtl/rv32i_decode_stage.sv - registered RV32I decode stage with one-entry skid buffer and coverage counters
module rv32i_decode_stage
  import rv32i_decode_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rv32i_decode_stage_if.slave bus,
  output logic [CNT_W-1:0] decode_count,
  output logic [CNT_W-1:0] illegal_count
);

  instr_t   in_word;
  decoded_t dec, out_q, skid_q;
  logic     out_vld, skid_vld;
  logic     accept, drain;

  assign in_word.raw = bus.in_instr;

  rv32i_decode_comb u_decode (
    .instr (in_word),
    .pc    (bus.in_pc),
    .dec   (dec)
  );

  // in_ready depends only on skid occupancy, so out_ready never reaches it combinationally.
  assign bus.in_ready = !skid_vld;
  assign accept       = bus.in_valid && !skid_vld;
  assign drain        = out_vld && bus.out_ready;

  assign bus.out_valid   = out_vld;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_opcode  = out_q.opcode;
  assign bus.out_funct3  = out_q.funct3;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_imm_sel = out_q.imm_sel;
  assign bus.out_alt     = out_q.alt;
  assign bus.out_rd_we   = out_q.rd_we;
  assign bus.out_illegal = out_q.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld       <= 1'b0;
      skid_vld      <= 1'b0;
      out_q         <= '0;
      skid_q        <= '0;
      decode_count  <= '0;
      illegal_count <= '0;
    end else begin
      if (!out_vld || bus.out_ready) begin
        // A full skid implies in_ready was low, so no new word competes for the slot.
        if (skid_vld) begin
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= 1'b0;
        end else if (accept) begin
          out_q   <= dec;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (accept) begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end

      if (drain) begin
        if (decode_count != '1)
          decode_count <= decode_count + CNT_W'(1);
        if (out_q.illegal && illegal_count != '1)
          illegal_count <= illegal_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb/tb_rv32i_decode_stage.sv - self-checking bench for rv32i_decode_stage with reference decoder and scoreboard
module tb_rv32i_decode_stage;
  import rv32i_decode_stage_pkg::*;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] dcnt, icnt;

  rv32i_decode_stage_if bus ();

  rv32i_decode_stage #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .decode_count  (dcnt),
    .illegal_count (icnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  decoded_t    exp_q[$];
  int          exp_dec = 0;
  int          exp_ill = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input decoded_t obs, input decoded_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed instr %h imm %h sel %0d alt %b we %b ill %b pc %h, expected instr %h imm %h sel %0d alt %b we %b ill %b pc %h",
             tag, obs.instr, obs.imm, obs.imm_sel, obs.alt, obs.rd_we, obs.illegal, obs.pc,
             exp.instr, exp.imm, exp.imm_sel, exp.alt, exp.rd_we, exp.illegal, exp.pc);
    end
  endtask

  // Reference decoder written from the RV32I base rules with plain arithmetic.
  function automatic decoded_t ref_dec(input logic [31:0] pc, input logic [31:0] w);
    decoded_t d;
    int f3, f7;
    bit ok, wr, alt;
    imm_sel_t fmt;
    logic signed [12:0] b;
    logic signed [20:0] j;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    ok = 1; wr = 1; alt = 0; fmt = IMM_NONE;
    case (w[6:0])
      7'h37, 7'h17: fmt = IMM_U;
      7'h6F: fmt = IMM_J;
      7'h67: begin fmt = IMM_I; ok = (f3 == 0); end
      7'h03: begin fmt = IMM_I; ok = (f3 inside {0, 1, 2, 4, 5}); end
      7'h23: begin fmt = IMM_S; wr = 0; ok = (f3 <= 2); end
      7'h63: begin fmt = IMM_B; wr = 0; ok = !(f3 inside {2, 3}); end
      7'h13: begin
        fmt = IMM_I;
        if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); alt = (f7 == 32); end
      end
      7'h33: begin ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); alt = (f7 == 32); end
      default: ok = 0;
    endcase
    d = '0;
    d.pc = pc; d.instr = w; d.opcode = w[6:0]; d.funct3 = w[14:12];
    d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
    d.illegal = !ok;
    if (ok) begin
      d.imm_sel = fmt;
      d.alt = alt;
      d.rd_we = wr && (w[11:7] != 5'd0);
      b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      case (fmt)
        IMM_I: d.imm = 32'($signed(w) >>> 20);
        IMM_S: begin d.imm = 32'($signed(w) >>> 20); d.imm[4:0] = w[11:7]; end
        IMM_B: d.imm = 32'(b);
        IMM_U: d.imm = w & 32'hFFFF_F000;
        IMM_J: d.imm = 32'(j);
        default: d.imm = 32'd0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [6:0] ops[10];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h00};
    w = $urandom;
    ops[9] = w[6:0] ^ 7'h55;
    w[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
    return w;
  endfunction

  // Scoreboard: handoffs and acceptances are decided by values stable at the falling edge.
  always @(negedge clk) begin
    decoded_t got, exp_rec;
    if (rst_n) begin
      check32("decode_count", 32'(dcnt), 32'(exp_dec));
      check32("illegal_count", 32'(icnt), 32'(exp_ill));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check32("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          got = '0;
          got.pc = bus.out_pc; got.instr = bus.out_instr; got.opcode = bus.out_opcode;
          got.funct3 = bus.out_funct3; got.rd = bus.out_rd; got.rs1 = bus.out_rs1;
          got.rs2 = bus.out_rs2; got.imm = bus.out_imm; got.imm_sel = bus.out_imm_sel;
          got.alt = bus.out_alt; got.rd_we = bus.out_rd_we; got.illegal = bus.out_illegal;
          exp_rec = exp_q.pop_front();
          check_rec("record", got, exp_rec);
          exp_dec = (exp_dec < CNT_MAX) ? exp_dec + 1 : CNT_MAX;
          if (exp_rec.illegal) exp_ill = (exp_ill < CNT_MAX) ? exp_ill + 1 : CNT_MAX;
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_dec(bus.in_pc, bus.in_instr));
    end
  end

  task automatic send(input logic [31:0] w);
    bit done;
    done = 0;
    bus.in_valid = 1'b1; bus.in_instr = w; bus.in_pc = pc_ctr;
    pc_ctr += 32'd4;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check32("send_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete(); exp_dec = 0; exp_ill = 0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] bp_w[4];
    logic [31:0] sat_w;
    int acc, idx;
    bit ok;
    bp_w = '{32'h0050_0093, 32'h00A0_8113, 32'h0020_81B3, 32'h0041_A023};
    sat_w = 32'h0010_0093;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check32("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check32("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check32("reset_out_imm", bus.out_imm, 32'd0);

    bus.out_ready = 1'b1;
    send(32'hFFF0_0093);
    check32("addi_valid", 32'(bus.out_valid), 32'd1);
    check32("addi_rd", 32'(bus.out_rd), 32'd1);
    check32("addi_rs1", 32'(bus.out_rs1), 32'd0);
    check32("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
    check32("addi_sel", 32'(bus.out_imm_sel), 32'(IMM_I));
    check32("addi_we", 32'(bus.out_rd_we), 32'd1);
    check32("addi_ill", 32'(bus.out_illegal), 32'd0);
    send(32'hFE00_0EE3);
    check32("beq_imm", bus.out_imm, 32'hFFFF_FFFC);
    check32("beq_sel", 32'(bus.out_imm_sel), 32'(IMM_B));
    check32("beq_we", 32'(bus.out_rd_we), 32'd0);
    send(32'h0010_00EF);
    check32("jal_imm", bus.out_imm, 32'h0000_0800);
    check32("jal_sel", 32'(bus.out_imm_sel), 32'(IMM_J));
    check32("jal_we", 32'(bus.out_rd_we), 32'd1);
    send(32'h4020_8033);
    check32("sub_alt", 32'(bus.out_alt), 32'd1);
    check32("sub_we", 32'(bus.out_rd_we), 32'd0);
    check32("sub_ill", 32'(bus.out_illegal), 32'd0);
    send(32'h0220_8033);
    check32("f7_ill", 32'(bus.out_illegal), 32'd1);
    check32("f7_sel", 32'(bus.out_imm_sel), 32'(IMM_NONE));
    send(32'h0000_007F);
    check32("op7f_ill", 32'(bus.out_illegal), 32'd1);
    @(posedge clk); #1;
    check32("illegal_count_2", 32'(icnt), 32'd2);

    // Fill output and skid, then reset asynchronously mid-cycle.
    bus.out_ready = 1'b0;
    send(32'h0010_0093);
    send(32'h0020_0113);
    check32("full_in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    exp_q.delete(); exp_dec = 0; exp_ill = 0;
    #1;
    check32("async_out_valid", 32'(bus.out_valid), 32'd0);
    check32("async_dcnt", 32'(dcnt), 32'd0);
    check32("async_icnt", 32'(icnt), 32'd0);
    check32("async_in_ready", 32'(bus.in_ready), 32'd1);
    check32("async_out_instr", bus.out_instr, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'h0030_0193);
    check32("post_reset_valid", 32'(bus.out_valid), 32'd1);
    check32("post_reset_instr", bus.out_instr, 32'h0030_0193);

    // Backpressure: four words offered while the consumer stalls for three cycles.
    do_reset();
    acc = 0; idx = 0;
    bus.in_valid = 1'b1; bus.in_instr = bp_w[0]; bus.in_pc = pc_ctr;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (c == 2) check32("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      if (ok) begin acc++; idx++; pc_ctr += 4; bus.in_instr = bp_w[idx]; bus.in_pc = pc_ctr; end
    end
    check32("bp_accepted", 32'(acc), 32'd2);
    check32("bp_stable_instr", bus.out_instr, bp_w[0]);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check32("bp_back_to_back", 32'(bus.out_valid), 32'd1);
      ok = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (ok) begin
        idx++; pc_ctr += 4;
        if (idx < 4) begin bus.in_instr = bp_w[idx]; bus.in_pc = pc_ctr; end
        else bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check32("bp_decode_count", 32'(dcnt), 32'd4);
    check32("bp_drained", 32'(bus.out_valid), 32'd0);

    // Saturation: 2^CW + 2 handoffs.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < (1 << CW) + 2; i++) send(sat_w);
    @(posedge clk); #1;
    check32("sat_decode_count", 32'(dcnt), 32'(CNT_MAX));

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      ok = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (ok || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_instr = rand_word();
        bus.in_pc = $urandom;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check32("random_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
